// File: rtl/matrix_stream_loader.sv
// matrix_stream_loader
//   Buffers a 50-byte operand stream (A row-major, then B row-major) and then
//   drives the skewed west/north edge feed of a 5x5 systolic array, followed
//   by a zero flush and a one-cycle completion pulse.
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_data/in_valid      operand byte stream from the host
//   in_ready              byte accepted this cycle (LOAD only, low during rst)
//   a1..a5                west-edge operands, row i-1 of A, skewed by i-1
//   b1..b5                north-edge operands, column j-1 of B, skewed by j-1
//   feed_valid            high for the 9 skewed data cycles
//   busy                  high in FEED, FLUSH and DONE
//   feed_done             one-cycle pulse after feed and flush
module matrix_stream_loader #(
  parameter int DW        = 8,
  parameter int FLUSH_CYC = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] a1,
  output logic [DW-1:0] a2,
  output logic [DW-1:0] a3,
  output logic [DW-1:0] a4,
  output logic [DW-1:0] a5,
  output logic [DW-1:0] b1,
  output logic [DW-1:0] b2,
  output logic [DW-1:0] b3,
  output logic [DW-1:0] b4,
  output logic [DW-1:0] b5,
  output logic          feed_valid,
  output logic          busy,
  output logic          feed_done
);

  localparam int NB  = 50;
  localparam int FCW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  typedef enum logic [1:0] {LOAD, FEED, FLUSH, DONE} state_t;

  state_t          state, next_state;
  logic [5:0]      k;
  logic [3:0]      t;
  logic [FCW-1:0]  fcnt;
  logic [DW-1:0]   buffer [NB];
  logic            xfer;
  logic [DW-1:0]   a_lane [5];
  logic [DW-1:0]   b_lane [5];

  assign in_ready = (state == LOAD) && !rst;
  assign xfer     = in_valid && in_ready;

  always_comb begin
    next_state = state;
    case (state)
      LOAD:  if (xfer && k == 6'd49) next_state = FEED;
      FEED:  if (t == 4'd8) next_state = (FLUSH_CYC == 0) ? DONE : FLUSH;
      FLUSH: if (fcnt == FCW'(FLUSH_CYC - 1)) next_state = DONE;
      DONE:  next_state = LOAD;
      default: next_state = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      k     <= '0;
      t     <= '0;
      fcnt  <= '0;
    end else begin
      state <= next_state;
      case (state)
        LOAD: begin
          t    <= '0;
          fcnt <= '0;
          if (xfer) k <= (k == 6'd49) ? '0 : k + 6'd1;
        end
        FEED:  t <= (t == 4'd8) ? '0 : t + 4'd1;
        FLUSH: fcnt <= (next_state == DONE) ? '0 : fcnt + FCW'(1);
        DONE: begin
          k    <= '0;
          t    <= '0;
          fcnt <= '0;
        end
        default: ;
      endcase
    end
  end

  // Operand storage is deliberately not reset: FEED is only reachable after
  // 50 fresh writes, so stale contents can never reach the outputs.
  always_ff @(posedge clk) begin
    if (xfer) buffer[k] <= in_data;
  end

  // Lane i carries element t-i of its row/column while 0 <= t-i <= 4.
  always_comb begin
    for (int unsigned i = 0; i < 5; i++) begin
      a_lane[i] = '0;
      b_lane[i] = '0;
    end
    if (state == FEED) begin
      for (int unsigned i = 0; i < 5; i++) begin
        if (32'(t) >= i && 32'(t) - i <= 32'd4) begin
          a_lane[i] = buffer[6'(5 * i + 32'(t) - i)];
          b_lane[i] = buffer[6'(25 + 5 * (32'(t) - i) + i)];
        end
      end
    end
  end

  assign a1 = a_lane[0];
  assign a2 = a_lane[1];
  assign a3 = a_lane[2];
  assign a4 = a_lane[3];
  assign a5 = a_lane[4];
  assign b1 = b_lane[0];
  assign b2 = b_lane[1];
  assign b3 = b_lane[2];
  assign b4 = b_lane[3];
  assign b5 = b_lane[4];

  assign feed_valid = (state == FEED);
  assign busy       = (state != LOAD);
  assign feed_done  = (state == DONE);

endmodule

// File: tb/tb_matrix_stream_loader.sv
// tb_matrix_stream_loader
//   Scoreboarded bench: the driver streams jobs and, on the 50th accepted byte,
//   pushes the full expected busy-period trace (9 feed, flush, done) computed
//   from the matrix definitions. A monitor sampling 1 time unit after each
//   rising edge pops one entry per cycle while work is expected, and otherwise
//   checks the idle outputs.
module tb_matrix_stream_loader;

  localparam int DW        = 8;
  localparam int FLUSH_CYC = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a1, a2, a3, a4, a5, b1, b2, b3, b4, b5;
  logic          feed_valid, busy, feed_done;

  matrix_stream_loader #(.DW(DW), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready),
    .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5),
    .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5),
    .feed_valid(feed_valid), .busy(busy), .feed_done(feed_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0][DW-1:0] a;
    logic [4:0][DW-1:0] b;
    logic               fv;
    logic               fd;
    int                 exp_cyc;
  } item_t;

  item_t         exp_q[$];
  logic [DW-1:0] job_bytes [50];
  int            cyc = 0;
  int            assertions = 0;
  int            failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected trace straight from the matrix definition:
  // a_i = A[i][t-i], b_j = B[t-j][j], A[r][c]=byte[5r+c], B[r][c]=byte[25+5r+c].
  task automatic push_job();
    item_t e;
    for (int t = 0; t < 9; t++) begin
      e = '0;
      e.fv = 1'b1;
      for (int i = 0; i < 5; i++) begin
        int d;
        d = t - i;
        if (d >= 0 && d <= 4) begin
          e.a[i] = job_bytes[5 * i + d];
          e.b[i] = job_bytes[25 + 5 * d + i];
        end
      end
      exp_q.push_back(e);
    end
    for (int f = 0; f < FLUSH_CYC; f++) begin
      e = '0;
      exp_q.push_back(e);
    end
    e = '0;
    e.fd = 1'b1;
    e.exp_cyc = cyc + 9 + FLUSH_CYC + 1;
    exp_q.push_back(e);
  endtask

  // Streams the first n bytes of job_bytes; returns after the final transfer
  // has been decided, before the edge that performs it.
  task automatic send_job(input int n, input int vprob);
    int idx;
    int guard;
    idx = 0;
    guard = 0;
    while (idx < n) begin
      @(negedge clk);
      guard++;
      if (guard > 3000) begin
        assertions++;
        failures++;
        $display("FAIL send_timeout: accepted %0d bytes, required %0d", idx, n);
        in_valid = 1'b0;
        return;
      end
      if (int'($urandom_range(99)) < vprob) begin
        in_valid = 1'b1;
        in_data  = job_bytes[idx];
      end else begin
        in_valid = 1'b0;
        in_data  = DW'($urandom);
      end
      if (in_valid && in_ready) begin
        idx++;
        if (idx == 50) push_job();
      end
    end
  endtask

  // Waits for the scoreboard to drain, optionally toggling in_valid with junk.
  task automatic wait_done(input bit noise);
    int guard;
    guard = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
      guard++;
      if (guard > 200) begin
        assertions++;
        failures++;
        $display("FAIL done_timeout: %0d entries left, required 0", exp_q.size());
        exp_q.delete();
        break;
      end
      in_valid = noise ? 1'($urandom_range(1)) : 1'b0;
      in_data  = DW'($urandom);
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fill_seq(input int base);
    for (int i = 0; i < 50; i++) job_bytes[i] = DW'(base + i);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 50; i++) job_bytes[i] = DW'($urandom);
  endtask

  // Monitor
  initial begin
    item_t              e;
    logic [4:0][DW-1:0] act_a, act_b;
    forever begin
      @(posedge clk);
      #1;
      act_a = {a5, a4, a3, a2, a1};
      act_b = {b5, b4, b3, b2, b1};
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        assertions++;
        if (act_a !== e.a || act_b !== e.b || feed_valid !== e.fv ||
            feed_done !== e.fd || busy !== 1'b1 || in_ready !== 1'b0) begin
          failures++;
          $display("FAIL busy_cycle @%0d: a=%h b=%h fv=%b fd=%b busy=%b rdy=%b, required a=%h b=%h fv=%b fd=%b busy=1 rdy=0",
                   cyc, act_a, act_b, feed_valid, feed_done, busy, in_ready,
                   e.a, e.b, e.fv, e.fd);
        end
        if (e.fd) begin
          assertions++;
          if (cyc != e.exp_cyc) begin
            failures++;
            $display("FAIL done_latency: cycle %0d, required %0d", cyc, e.exp_cyc);
          end
        end
      end else begin
        assertions++;
        if (act_a !== '0 || act_b !== '0 || feed_valid !== 1'b0 ||
            feed_done !== 1'b0 || busy !== 1'b0 || in_ready !== !rst) begin
          failures++;
          $display("FAIL idle_cycle @%0d: a=%h b=%h fv=%b fd=%b busy=%b rdy=%b, required zeros, busy=0 rdy=%b",
                   cyc, act_a, act_b, feed_valid, feed_done, busy, in_ready, !rst);
        end
      end
    end
  end

  // Stimulus
  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // T1: bytes 1..50, continuous valid
    fill_seq(1);
    send_job(50, 100);
    wait_done(1'b0);

    // T2: A = identity, B[r][c] = 5r+c+1
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        job_bytes[5 * r + c]      = (r == c) ? DW'(1) : DW'(0);
        job_bytes[25 + 5 * r + c] = DW'(5 * r + c + 1);
      end
    send_job(50, 100);
    wait_done(1'b0);

    // T3: gappy valid, junk valid pulses while busy
    fill_seq(1);
    send_job(50, 40);
    wait_done(1'b1);

    // T4: reset during FEED t=4, then a fresh load
    fill_rand();
    send_job(50, 100);
    repeat (4) @(negedge clk);
    do_reset();
    fill_rand();
    send_job(50, 70);
    wait_done(1'b1);

    // T5: reset after 30 bytes, then 101..150
    fill_rand();
    send_job(30, 100);
    do_reset();
    fill_seq(101);
    send_job(50, 100);
    wait_done(1'b0);

    // T6: back-to-back jobs, valid held high throughout
    fill_rand();
    send_job(50, 100);
    fill_rand();
    send_job(50, 100);
    wait_done(1'b0);

    // Extra random jobs
    for (int j = 0; j < 3; j++) begin
      fill_rand();
      send_job(50, int'($urandom_range(30, 100)));
      wait_done(1'b1);
    end

    repeat (3) @(negedge clk);
    assertions++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL final_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
